// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one shared full-subtractor slice walks the operands LSB
// first over WIDTH cycles, then presents a - b - bin with borrow-out for one DONE cycle.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Returns {borrow, diff} for one bit position.
    function automatic logic [1:0] sub_slice(input logic x, input logic y, input logic br);
        logic diff;
        logic borrow;
        diff   = x ^ y ^ br;
        borrow = (~x & y) | (~(x ^ y) & br);
        return {borrow, diff};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bo_q, bo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       slice_s;

    assign slice_s = sub_slice(a_sh_q[0], b_sh_q[0], br_q);

    // Next-state and datapath: d/bo are only loaded on the final bit so partial sums never leak out.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bo_d    = bo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d  = {slice_s[0], res_q[WIDTH-1:1]};
                br_d   = slice_s[1];
                if (cnt_q == LAST_BIT) begin
                    d_d     = {slice_s[0], res_q[WIDTH-1:1]};
                    bo_d    = slice_s[1];
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and registered Moore outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bo_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bo_q    <= bo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bo   = bo_q;

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; captured on the accepting edge.
REQ-006 b  input  WIDTH  subtrahend; captured on the accepting edge.
REQ-007 bin  input  1  borrow-in; captured on the accepting edge.
REQ-008 busy  output  1  high while bits are being processed (SHIFT state).
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 d  output  WIDTH  difference a - b - bin, modulo 2^WIDTH.
REQ-011 bo  output  1  borrow-out; high when a < b + bin (unsigned).

Function
REQ-012 Block SHALL sequence one shared 1-bit full-subtractor slice, LSB first, over WIDTH cycles; no WIDTH-wide subtractor permitted.
REQ-013 Slice SHALL compute diff = x ^ y ^ br and borrow = (~x & y) | (~(x ^ y) & br).
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE; encoding free; no other reachable states.
REQ-015 IDLE: if start=1 at an edge, capture a, b into shift registers, bin into the borrow register, clear the bit counter, go to SHIFT; else stay.
REQ-016 SHIFT: each edge processes the current LSB pair, shifts the operands right, shifts diff into the result MSB, updates the borrow register, increments the counter.
REQ-017 SHIFT -> DONE on the edge that processes bit WIDTH-1; d and bo SHALL be updated on that same edge.
REQ-018 DONE SHALL last exactly one cycle, then go to IDLE unconditionally.
REQ-019 Latency: if start is accepted at edge 0, busy SHALL be high for cycles after edges 0..WIDTH-1 and done high only for the cycle after edge WIDTH.
REQ-020 busy and done SHALL be Moore outputs, never high together.
REQ-021 start SHALL be ignored in SHIFT and DONE; no queueing; captured operands unaffected by input changes after acceptance.
REQ-022 d and bo SHALL hold the last result until the next completion; intermediate shift values SHALL never appear on d.
REQ-023 Back-to-back: start held high continuously SHALL yield one operation per WIDTH+2 cycles.
REQ-024 Counter SHALL be ceil(log2(WIDTH)) bits minimum and SHALL NOT wrap within an operation.

Reset
REQ-025 rst_n=0 SHALL immediately, independent of clk, force state IDLE, busy=0, done=0, d=0, bo=0, counter and shift/borrow registers to 0.
REQ-026 Reset mid-SHIFT or in DONE SHALL abort the operation with no done pulse; first start accepted on the first rising edge with rst_n=1.

Verification
REQ-027 WIDTH=8, a=0x05, b=0x03, bin=0 -> d=0x02, bo=0, done exactly 8 edges after the accepting edge, busy high 8 cycles.
REQ-028 WIDTH=8, a=0x03, b=0x05, bin=0 -> d=0xFE, bo=1; a=0x00, b=0x00, bin=1 -> d=0xFF, bo=1.
REQ-029 WIDTH=8, a=0xFF, b=0x00, bin=0 then start pulsed again at busy cycle 3 with a=0x01, b=0x01 -> single done, d=0xFF, bo=0; second start ignored.
REQ-030 rst_n pulsed low at SHIFT cycle 4 -> busy, done, d, bo all 0 asynchronously; no done pulse; new op a=0x10, b=0x01 -> d=0x0F, bo=0.
REQ-031 start held high for 3 operations with a, b changing each cycle -> done pulses spaced 10 cycles, each result matching operands present at its accepting edge.
REQ-032 Exhaustive WIDTH=4 sweep, all 512 (a, b, bin) -> d, bo match reference a - b - bin modulo 16 with borrow.
